// File: rtl/systolic_feeder_pkg.sv
// -----------------------------------------------------------------------------
// systolic_feeder_pkg
//   Shared definitions for the systolic array input feeder: default array
//   geometry and data widths, the feeder state encoding, and small helper
//   functions used to size counters and derive the stream length.
// -----------------------------------------------------------------------------
package systolic_feeder_pkg;

    // Defaults matching the 4x4 systolic array this block feeds.
    localparam int ROWS_DEF      = 4;
    localparam int COLS_DEF      = 4;
    localparam int K_DEF         = 4;
    localparam int WEST_DW_DEF   = 8;
    localparam int NORTH_DW_DEF  = 8;
    localparam int DRAIN_CYC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the values 0 .. n-1 (never less than one bit).
    function automatic int width_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Stream length: the last lane is offset by max(ROWS,COLS)-1 cycles and
    // still has to emit all K of its elements.
    function automatic int stream_len(input int k, input int rows, input int cols);
        return k + max_int(rows, cols) - 1;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// -----------------------------------------------------------------------------
// systolic_skew_lane
//   One feeder lane: a K-entry element buffer plus the skewed read-out for a
//   lane sitting OFFSET cycles behind lane 0. When load_en is high the element
//   for stream cycle load_t is registered onto lane_out, or zero when that
//   cycle falls outside this lane's K-element window; otherwise lane_out
//   registers zero.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   wr_en    in   write strobe, already qualified for this lane
//   wr_k     in   reduction index of the element being written
//   wr_data  in   element data
//   load_en  in   register the element for stream cycle load_t
//   load_t   in   stream cycle whose value is loaded this edge
//   lane_out out  registered lane value toward the array edge
// -----------------------------------------------------------------------------
module systolic_skew_lane #(
    parameter int DW     = 8,
    parameter int K      = 4,
    parameter int OFFSET = 0,
    parameter int T_W    = 4,
    parameter int K_W    = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [K_W-1:0] wr_k,
    input  logic [DW-1:0]  wr_data,
    input  logic           load_en,
    input  logic [T_W-1:0] load_t,
    output logic [DW-1:0]  lane_out
);

    logic [DW-1:0] mem [K];
    logic [DW-1:0] sel;
    int            idx;

    // Element index this lane emits at stream cycle load_t.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and no latch is inferred.
        sel = '0;
        idx = int'(load_t) - OFFSET;
        if (load_en && idx >= 0 && idx < K) begin
            sel = mem[idx[K_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the buffer is reset on purpose: a reset must leave a tile of zeros, so a restart streams zeros.
            for (int i = 0; i < K; i++) begin
                mem[i] <= '0;
            end
            lane_out <= '0;
        end else begin
            // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
            if (wr_en && int'(wr_k) < K) begin
                mem[wr_k] <= wr_data;
            end
            lane_out <= sel;
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
//   Input staging and skew stage in front of a ROWS x COLS systolic array.
//   Holds an activation tile A[ROWS][K] and a weight tile B[K][COLS] loaded
//   through a write port while idle. On start it streams A into the west edge
//   and B into the north edge with lane i delayed i cycles (zero-filled), then
//   idles the edges for DRAIN_CYC cycles and pulses done.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   wr_en      in   buffer write strobe (honoured only when idle)
//   wr_sel     in   0 = A (activation) buffer, 1 = B (weight) buffer
//   wr_lane    in   row index for A, column index for B
//   wr_k       in   reduction index
//   wr_data    in   write data; low WEST_DW / NORTH_DW bits used
//   start      in   begin streaming (idle only, ignored together with wr_en)
//   busy       out  high while streaming and draining
//   done       out  one-cycle pulse after the drain period
//   out_valid  out  high while the edges carry stream cycles
//   west_out   out  lane r at [r*WEST_DW +: WEST_DW]
//   north_out  out  lane c at [c*NORTH_DW +: NORTH_DW]
// -----------------------------------------------------------------------------
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int K         = K_DEF,
    parameter int WEST_DW   = WEST_DW_DEF,
    parameter int NORTH_DW  = NORTH_DW_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int LANE_W    = width_for(max_int(ROWS, COLS)),
    parameter int K_W       = width_for(K),
    parameter int DATA_W    = max_int(WEST_DW, NORTH_DW)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [LANE_W-1:0]        wr_lane,
    input  logic [K_W-1:0]           wr_k,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     out_valid,
    output logic [ROWS*WEST_DW-1:0]  west_out,
    output logic [COLS*NORTH_DW-1:0] north_out
);

    localparam int L     = stream_len(K, ROWS, COLS);
    localparam int CNT_W = width_for(L + DRAIN_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_T     = CNT_W'(L - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(DRAIN_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             in_idle;
    logic             take_start;
    logic             wr_ok;
    logic             load_en;
    logic [CNT_W-1:0] load_t;

    assign in_idle    = (state == IDLE);
    assign wr_ok      = in_idle && wr_en;
    // A write in the same cycle wins over start.
    assign take_start = in_idle && start && !wr_en;

    // The lanes register the value of the stream cycle that begins after this
    // edge: t=0 on the edge that accepts start, t+1 while streaming, and zero
    // once the last stream cycle has been shown.
    always_comb begin
        load_en = 1'b0;
        load_t  = '0;
        case (state)
            IDLE: begin
                if (take_start) begin
                    load_en = 1'b1;
                end
            end
            STREAM: begin
                if (cnt != LAST_T) begin
                    load_en = 1'b1;
                    load_t  = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control FSM; cnt is the stream cycle in STREAM and the drain cycle in
    // DRAIN, and its width leaves room for the whole run without wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_start) begin
                        state     <= STREAM;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (cnt == LAST_T) begin
                        state     <= DRAIN;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == LAST_DRAIN) begin
                        state <= DONE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // West lanes: row r of A, delayed r cycles. Out-of-range lane indices
    // match no instance and are dropped.
    for (genvar r = 0; r < ROWS; r++) begin : g_west
        logic a_wr;
        assign a_wr = wr_ok && !wr_sel && (wr_lane == LANE_W'(r));

        systolic_skew_lane #(
            .DW     (WEST_DW),
            .K      (K),
            .OFFSET (r),
            .T_W    (CNT_W),
            .K_W    (K_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (a_wr),
            .wr_k     (wr_k),
            .wr_data  (wr_data[WEST_DW-1:0]),
            .load_en  (load_en),
            .load_t   (load_t),
            .lane_out (west_out[r*WEST_DW +: WEST_DW])
        );
    end

    // North lanes: column c of B, delayed c cycles.
    for (genvar c = 0; c < COLS; c++) begin : g_north
        logic b_wr;
        assign b_wr = wr_ok && wr_sel && (wr_lane == LANE_W'(c));

        systolic_skew_lane #(
            .DW     (NORTH_DW),
            .K      (K),
            .OFFSET (c),
            .T_W    (CNT_W),
            .K_W    (K_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (b_wr),
            .wr_k     (wr_k),
            .wr_data  (wr_data[NORTH_DW-1:0]),
            .load_en  (load_en),
            .load_t   (load_t),
            .lane_out (north_out[c*NORTH_DW +: NORTH_DW])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
//   Directed bench for systolic_feeder with default geometry (4x4, K=4,
//   8-bit data, drain 4) and the lane field widened to 3 bits so that
//   out-of-range lane indices can be presented.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int K      = 4;
    localparam int L      = 7;
    localparam int DRAIN  = 4;
    localparam int LANE_W = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [2:0]  wr_lane = '0;
    logic [1:0]  wr_k = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic [31:0] west_out;
    logic [31:0] north_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  a_ref [ROWS][K];
    logic [7:0]  b_ref [K][COLS];
    logic [31:0] west_log  [L];
    logic [31:0] north_log [L];
    int          valid_cnt;
    int          done_cnt;
    int          done_cycle;

    systolic_feeder #(
        .LANE_W (LANE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_lane   (wr_lane),
        .wr_k      (wr_k),
        .wr_data   (wr_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .west_out  (west_out),
        .north_out (north_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_west(input int t);
        logic [31:0] v = '0;
        for (int r = 0; r < ROWS; r++) begin
            int i = t - r;
            if (i >= 0 && i < K) v[r*8 +: 8] = a_ref[r][i];
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_north(input int t);
        logic [31:0] v = '0;
        for (int c = 0; c < COLS; c++) begin
            int i = t - c;
            if (i >= 0 && i < K) v[c*8 +: 8] = b_ref[i][c];
        end
        return v;
    endfunction

    task automatic clear_refs();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a_ref[i][j] = '0;
                b_ref[i][j] = '0;
            end
        end
    endtask

    // Called at a negedge in IDLE; returns at the next negedge.
    task automatic write_elem(input bit sel, input int lane, input int k, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_lane = 3'(lane);
        wr_k    = 2'(k);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (lane < 4) begin
            if (!sel) a_ref[lane][k] = data;
            else      b_ref[k][lane] = data;
        end
    endtask

    // Start a run and follow it cycle by cycle; cyc counts cycles after the
    // edge that samples start. With lockout set, a write and a start are
    // presented in the middle of the stream.
    task automatic run_tile(input string name, input bit lockout);
        valid_cnt  = 0;
        done_cnt   = 0;
        done_cycle = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= L + DRAIN + 2; cyc++) begin
            if (out_valid) valid_cnt++;
            if (done) begin
                done_cnt++;
                done_cycle = cyc;
            end
            if (cyc <= L) begin
                west_log[cyc-1]  = west_out;
                north_log[cyc-1] = north_out;
                check({name, "_west"},  west_out,  exp_west(cyc - 1));
                check({name, "_north"}, north_out, exp_north(cyc - 1));
                check({name, "_busy_stream"}, 32'(busy), 32'd1);
            end else if (cyc <= L + DRAIN) begin
                check({name, "_west_drain"},  west_out,  32'd0);
                check({name, "_north_drain"}, north_out, 32'd0);
                check({name, "_busy_drain"},  32'(busy), 32'd1);
            end else begin
                check({name, "_busy_end"}, 32'(busy), 32'd0);
            end
            if (lockout && cyc == 3) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_lane = 3'd1;
                wr_k    = 2'd1;
                wr_data = 8'hAA;
                start   = 1'b1;
            end else begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
        end
        check({name, "_done_count"}, 32'(done_cnt),   32'd1);
        check({name, "_done_cycle"}, 32'(done_cycle), 32'd12);
        check({name, "_valid_count"}, 32'(valid_cnt), 32'd7);
        check({name, "_idle_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        clear_refs();

        // Reset, then idle with no stimulus.
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_west",  west_out,  32'd0);
        check("rst_north", north_out, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy",  32'(busy), 32'd0);
            check("idle_done",  32'(done), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_west",  west_out,  32'd0);
            check("idle_north", north_out, 32'd0);
        end

        // Identity-style tiles.
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < K; k++)
                write_elem(1'b0, r, k, 8'(16 * r + k + 1));
        for (int k = 0; k < K; k++)
            for (int c = 0; c < COLS; c++)
                write_elem(1'b1, c, k, 8'(16 * k + c + 1));
        run_tile("ident", 1'b0);
        check("ident_t0_west",  west_log[0], 32'h0000_0001);
        check("ident_t3_west3", 32'(west_log[3][31:24]), 32'h31);
        check("ident_t3_north0", 32'(north_log[3][7:0]), 32'h31);

        // Write and start together: the write lands, no run starts.
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_lane = 3'd0;
        wr_k    = 2'd0;
        wr_data = 8'h55;
        start   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        a_ref[0][0] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            check("collide_busy",  32'(busy), 32'd0);
            check("collide_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        run_tile("collide", 1'b0);
        check("collide_t0_lane0", 32'(west_log[0][7:0]), 32'h55);

        // Writes and start while busy are dropped.
        run_tile("lock", 1'b1);
        run_tile("after_lock", 1'b0);
        check("after_lock_a11", 32'(west_log[2][15:8]), 32'h12);

        // Lane index 5 is out of range for both buffers.
        write_elem(1'b0, 5, 0, 8'hEE);
        write_elem(1'b1, 5, 2, 8'hEE);
        run_tile("oor", 1'b0);
        check("oor_a00", 32'(west_log[0][7:0]), 32'h55);

        // Reset in the middle of a stream.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_t4_west", west_out, exp_west(4));
        rst = 1'b0;
        #1;
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_done",  32'(done), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_west",  west_out,  32'd0);
        check("abort_north", north_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clear_refs();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("post_abort_busy", 32'(busy), 32'd0);
            check("post_abort_done", 32'(done), 32'd0);
        end
        run_tile("cleared", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
